// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sort_pkg
//  Purpose  : Shared types, default widths and ordering helper for the
//             sort sequencer and its compare-swap unit.
//  Revision : 1.0  initial release
// ============================================================================
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widths for the default 8-entry buffer; the top recomputes them from its
    // own DEPTH so non-default instances stay consistent.
    localparam int DEPTH_DEFAULT = 8;
    localparam int IDXW          = $clog2(DEPTH_DEFAULT);
    localparam int PCW           = $clog2(DEPTH_DEFAULT) + 1;

    // True when a may stay ahead of b. Ties count as in order, which keeps
    // equal entries from ever being swapped.
    function automatic logic in_order(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic        descend);
        return descend ? (a >= b) : (a <= b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_cmp_swap.sv
`default_nettype none
// ============================================================================
//  Module   : sort_cmp_swap
//  Purpose  : Combinational compare-swap of one adjacent pair. lo/hi are the
//             values to write back into the lower/upper slot of the pair.
//  Revision : 1.0  initial release
// ============================================================================
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 3,
    parameter bit DESCEND  = 1'b0
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic [BITWIDTH-1:0] lo,
    output logic [BITWIDTH-1:0] hi,
    output logic                swap
);

    assign swap = !in_order(32'(a), 32'(b), DESCEND);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sort_sequencer
//  Purpose  : Serial-load sort buffer with a time-multiplexed bubble sort.
//             One shared compare-swap unit handles one adjacent pair per
//             cycle; a pass without swaps ends the sort early.
//  Revision : 1.0  initial release
// ============================================================================
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 3,
    parameter int DEPTH    = 8,
    parameter bit DESCEND  = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        din_valid,
    input  logic [BITWIDTH-1:0]         din,
    output logic                        din_ready,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [DEPTH*BITWIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]      pass_count
);

    localparam int J_W    = $clog2(DEPTH);
    localparam int PASS_W = J_W + 1;
    localparam logic [J_W-1:0] ONE        = J_W'(1);
    localparam logic [J_W-1:0] LIMIT_INIT = J_W'(DEPTH - 1);

    state_e                      state_q, state_d;
    logic [BITWIDTH-1:0]         mem_q [DEPTH];
    logic [BITWIDTH-1:0]         mem_d [DEPTH];
    logic [J_W-1:0]              j_q, j_d;
    logic [J_W-1:0]              limit_q, limit_d;
    logic                        swapped_q, swapped_d;
    logic [PASS_W-1:0]           passes_q, passes_d;
    logic [PASS_W-1:0]           pass_count_q, pass_count_d;
    logic [DEPTH*BITWIDTH-1:0]   dout_q, dout_d;

    logic [BITWIDTH-1:0]         cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic                        cmp_swap;

    // The single compare-swap unit always looks at the pair selected by j.
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_q + ONE];

    sort_cmp_swap #(
        .BITWIDTH (BITWIDTH),
        .DESCEND  (DESCEND)
    ) u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .lo   (cmp_lo),
        .hi   (cmp_hi),
        .swap (cmp_swap)
    );

    // Next-state, counter and buffer write-back logic.
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        j_d          = j_q;
        limit_d      = limit_q;
        swapped_d    = swapped_q;
        passes_d     = passes_q;
        pass_count_d = pass_count_q;
        dout_d       = dout_q;

        case (state_q)
            IDLE: begin
                // Shift before a same-cycle start so that word is sorted too.
                if (din_valid) begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        mem_d[i] = mem_q[i-1];
                    end
                    mem_d[0] = din;
                end
                if (start) begin
                    state_d   = SORT;
                    j_d       = '0;
                    limit_d   = LIMIT_INIT;
                    swapped_d = 1'b0;
                    passes_d  = '0;
                end
            end
            SORT: begin
                if (cmp_swap) begin
                    mem_d[j_q]       = cmp_lo;
                    mem_d[j_q + ONE] = cmp_hi;
                end
                if (j_q == limit_q - ONE) begin
                    passes_d = passes_q + PASS_W'(1);
                    if (!(swapped_q || cmp_swap) || (limit_q == ONE)) begin
                        state_d = DONE;
                    end else begin
                        limit_d   = limit_q - ONE;
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_q + ONE;
                    swapped_d = swapped_q || cmp_swap;
                end
            end
            DONE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    dout_d[i*BITWIDTH +: BITWIDTH] = mem_q[i];
                end
                pass_count_d = passes_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears the buffer and the published result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            j_q          <= '0;
            limit_q      <= LIMIT_INIT;
            swapped_q    <= 1'b0;
            passes_q     <= '0;
            pass_count_q <= '0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            j_q          <= j_d;
            limit_q      <= limit_d;
            swapped_q    <= swapped_d;
            passes_q     <= passes_d;
            pass_count_q <= pass_count_d;
            dout_q       <= dout_d;
        end
    end

    assign din_ready  = (state_q == IDLE);
    assign busy       = (state_q == SORT);
    assign done       = (state_q == DONE);
    assign dout       = dout_q;
    assign pass_count = pass_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_sequencer
//  Purpose  : Scoreboard bench for sort_sequencer (ascending and descending
//             instances) driven by directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sort_sequencer;

    typedef struct {
        logic [23:0] dout;
        logic [3:0]  pc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din_valid = 1'b0;
    logic [2:0]  din = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        din_ready_a, busy_a, done_a;
    logic        din_ready_b, busy_b, done_b;
    logic [23:0] dout_a, dout_b;
    logic [3:0]  pc_a, pc_b;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t cur[2];
    int   bcnt[2];
    bit   pend[2];

    always #5 clk = ~clk;

    sort_sequencer #(.BITWIDTH(3), .DEPTH(8), .DESCEND(1'b0)) dut_a (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .din_ready(din_ready_a), .start(start_a), .busy(busy_a),
        .done(done_a), .dout(dout_a), .pass_count(pc_a)
    );

    sort_sequencer #(.BITWIDTH(3), .DEPTH(8), .DESCEND(1'b1)) dut_b (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .din_ready(din_ready_b), .start(start_b), .busy(busy_b),
        .done(done_b), .dout(dout_b), .pass_count(pc_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7);
        logic [23:0] v;
        v = {3'(e7), 3'(e6), 3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
        return v;
    endfunction

    // Monitor: counts busy cycles, pops on done, checks result one cycle later.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        d_o, b_o;
            logic [23:0] q_o;
            logic [3:0]  p_o;
            string       tag;
            d_o = (k == 0) ? done_a : done_b;
            b_o = (k == 0) ? busy_a : busy_b;
            q_o = (k == 0) ? dout_a : dout_b;
            p_o = (k == 0) ? pc_a   : pc_b;
            tag = (k == 0) ? "asc" : "desc";
            if (reset) begin
                bcnt[k] = 0;
                pend[k] = 1'b0;
            end else begin
                if (pend[k]) begin
                    check({tag, " done_pulse"}, 32'(d_o), 32'd0);
                    check({tag, " dout"}, 32'(q_o), 32'(cur[k].dout));
                    check({tag, " pass_count"}, 32'(p_o), 32'(cur[k].pc));
                    pend[k] = 1'b0;
                end
                if (b_o) bcnt[k]++;
                if (d_o) begin
                    if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                        check({tag, " unexpected_done"}, 32'd1, 32'd0);
                    end else begin
                        cur[k] = (k == 0) ? qa.pop_front() : qb.pop_front();
                        check({tag, " latency"}, 32'(bcnt[k]), 32'(cur[k].lat));
                        pend[k] = 1'b1;
                    end
                    bcnt[k] = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int w);
        din_valid = 1'b1;
        din       = 3'(w);
        cyc();
        din_valid = 1'b0;
    endtask

    task automatic go(input int k, input logic [23:0] d, input int pc, input int lat);
        exp_t e;
        e.dout = d; e.pc = 4'(pc); e.lat = lat;
        if (k == 0) begin qa.push_back(e); start_a = 1'b1; end
        else        begin qb.push_back(e); start_b = 1'b1; end
        cyc();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (((k == 0 ? qa.size() : qb.size()) != 0 || pend[k]) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) begin
            check("wait_done_timeout", 32'd1, 32'd0);
            if (k == 0) qa.delete(); else qb.delete();
        end
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        cyc();
        do_reset();
        // Reset state
        check("rst din_ready", 32'(din_ready_a), 32'd1);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        check("rst dout", 32'(dout_a), 32'd0);
        check("rst pass_count", 32'(pc_a), 32'd0);

        // 1: already sorted
        for (int w = 7; w >= 0; w--) load(w);
        go(0, pk(0,1,2,3,4,5,6,7), 1, 7);
        wait_done(0);

        // 2: reverse order
        for (int w = 0; w <= 7; w++) load(w);
        go(0, pk(0,1,2,3,4,5,6,7), 7, 28);
        wait_done(0);

        // 3: descending instance with ties
        load(1); load(2); load(3); load(4); load(5); load(7); load(4); load(1);
        go(1, pk(7,5,4,4,3,2,1,1), 3, 18);
        wait_done(1);

        // 4: partial load after reset, zeros take part
        do_reset();
        load(2); load(5); load(1);
        go(0, pk(0,0,0,0,0,1,2,5), 4, 22);
        wait_done(0);

        // 5: load and start together, then disturb during SORT
        din_valid = 1'b1;
        din       = 3'd6;
        go(0, pk(0,0,0,0,0,1,2,6), 2, 13);
        din_valid = 1'b1;
        din       = 3'd7;
        start_a   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("sort din_ready", 32'(din_ready_a), 32'd0);
            check("sort dout_hold", 32'(dout_a), 32'(pk(0,0,0,0,0,1,2,5)));
            cyc();
        end
        din_valid = 1'b0;
        start_a   = 1'b0;
        wait_done(0);

        // 6: reset in the middle of a reverse sort
        for (int w = 0; w <= 7; w++) load(w);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        repeat (10) cyc();
        check("mid busy_before", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        check("mid busy", 32'(busy_a), 32'd0);
        check("mid done", 32'(done_a), 32'd0);
        check("mid dout", 32'(dout_a), 32'd0);
        check("mid pass_count", 32'(pc_a), 32'd0);
        check("mid din_ready", 32'(din_ready_a), 32'd1);
        cyc();
        reset = 1'b0;
        cyc();
        for (int w = 7; w >= 0; w--) load(w);
        go(0, pk(0,1,2,3,4,5,6,7), 1, 7);
        wait_done(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
